dpram_port_arbiter: RTL

//  Shares the single core-side port of the dual-port RAM between two requesters
//  (req 0: core data port, req 1: DMA/copy engine), one clock domain.

---
 rtl/dpram_port_arbiter_if.sv | 27 ++
 rtl/dpram_port_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the shared DPRAM core port: one instance per requester.
// The requester drives the request fields; the arbiter returns hit, rvalid and rdata.
interface dpram_port_arbiter_if #(
  parameter int unsigned ByteLength = 8,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32
);
  logic [AddrWidth-1:0]            addr;
  logic                            wren;
  logic [DataWidth-1:0]            wdata;
  logic [DataWidth/ByteLength-1:0] wmask;
  logic                            rden;
  logic                            lock;
  logic                            hit;
  logic                            rvalid;
  logic [DataWidth-1:0]            rdata;

  modport master (
    output addr, wren, wdata, wmask, rden, lock,
    input  hit, rvalid, rdata
  );

  modport slave (
    input  addr, wren, wdata, wmask, rden, lock,
    output hit, rvalid, rdata
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Two-requester round-robin arbiter for the single core-side port of the DPRAM.
// Combinational grant with bounded lock; read data returned with rvalid one cycle later.
module dpram_port_arbiter #(
  parameter int unsigned ByteLength = 8,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MaxBurst   = 4
) (
  input  logic                            core_clk_i,
  input  logic                            rstn_i,
  dpram_port_arbiter_if.slave             m0,
  dpram_port_arbiter_if.slave             m1,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic                            mem_wren_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [DataWidth/ByteLength-1:0] mem_wmask_o,
  output logic                            mem_rden_o,
  input  logic [DataWidth-1:0]            mem_rdata_i
);

  localparam int unsigned CntWidth = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxBurst - 1);

  logic                 req0, req1;
  logic                 grant_vld;
  logic                 winner;
  logic                 owner_lock;

  logic                 last_q, last_d;
  logic [CntWidth-1:0]  burst_cnt_q, burst_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_owner_q, rd_owner_d;
  logic [DataWidth-1:0] rdata0_q, rdata0_d;
  logic [DataWidth-1:0] rdata1_q, rdata1_d;

  // Grant decision
  always_comb begin
    req0       = m0.wren | m0.rden;
    req1       = m1.wren | m1.rden;
    grant_vld  = req0 | req1;
    owner_lock = last_q ? m1.lock : m0.lock;
    if (req0 && req1) begin
      // The last owner keeps the port only while locking and under the burst bound.
      winner = (owner_lock && (burst_cnt_q < CntMax)) ? last_q : ~last_q;
    end else begin
      winner = ~req0;
    end
  end

  assign m0.hit = grant_vld & ~winner;
  assign m1.hit = grant_vld &  winner;

  // Memory-side mux; all fields forced to zero when nobody is granted
  always_comb begin
    mem_addr_o  = '0;
    mem_wren_o  = 1'b0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    mem_rden_o  = 1'b0;
    if (grant_vld) begin
      if (winner) begin
        mem_addr_o  = m1.addr;
        mem_wren_o  = m1.wren;
        mem_wdata_o = m1.wdata;
        mem_wmask_o = m1.wmask;
        mem_rden_o  = m1.rden;
      end else begin
        mem_addr_o  = m0.addr;
        mem_wren_o  = m0.wren;
        mem_wdata_o = m0.wdata;
        mem_wmask_o = m0.wmask;
        mem_rden_o  = m0.rden;
      end
    end
  end

  // Ownership and burst tracking
  always_comb begin
    last_d      = last_q;
    burst_cnt_d = '0;
    if (grant_vld) begin
      last_d = winner;
      if (winner == last_q) begin
        burst_cnt_d = (burst_cnt_q == CntMax) ? burst_cnt_q : burst_cnt_q + CntWidth'(1);
      end
    end
  end

  // Read return tracking and per-requester held read data
  always_comb begin
    rd_pend_d  = mem_rden_o;
    rd_owner_d = mem_rden_o ? winner : rd_owner_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    if (rd_pend_q) begin
      if (rd_owner_q) begin
        rdata1_d = mem_rdata_i;
      end else begin
        rdata0_d = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge core_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // During the return cycle the RAM data is forwarded directly so rdata is valid with rvalid.
  assign m0.rvalid = rd_pend_q & ~rd_owner_q;
  assign m1.rvalid = rd_pend_q &  rd_owner_q;
  assign m0.rdata  = m0.rvalid ? mem_rdata_i : rdata0_q;
  assign m1.rdata  = m1.rvalid ? mem_rdata_i : rdata1_q;

endmodule
